// File: rtl/alu_mc_if.sv
// alu_mc_if: handshake bundle between the operand source, the multi-cycle ALU
// and the result consumer.
//   in_valid/in_ready   : operation handshake (A, B, ALUControl qualified by it)
//   out_valid/out_ready : result handshake (ALUResult and flags qualified by it)
// Modports:
//   master : the pipeline side (drives operands/opcode and out_ready)
//   slave  : the ALU side (drives in_ready, result and flags)
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Neg;
  logic             Carry;
  logic             Overflow;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Neg, Carry, Overflow
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Neg, Carry, Overflow
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle WIDTH-bit integer ALU with valid/ready on both sides.
// Single-cycle ops (ADD..SRA) return one cycle after acceptance. MUL/MULHU
// use an iterative shift-add multiplier and DIVU/REMU a restoring divider,
// each retiring one bit per cycle and returning WIDTH+1 cycles after
// acceptance.
// Build option: define ALU_MULDIV_EN to include the iterative multiply/divide
// datapath. Without it, opcodes 1010-1101 behave as reserved (result 0).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_mc_if.slave (operand/opcode handshake, result/flag handshake)
//   busy  : high while an iterative operation is in progress
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus,
  output logic    busy
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0, OP_SUB   = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR   = 4'h4, OP_SLT   = 4'h5, OP_SLTU = 4'h6, OP_SLL  = 4'h7,
    OP_SRL   = 4'h8, OP_SRA   = 4'h9, OP_MUL  = 4'hA, OP_MULHU = 4'hB,
    OP_DIVU  = 4'hC, OP_REMU  = 4'hD
  } op_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             is_iter;
  logic             load_res;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_res, nxt_res;
  logic             sc_carry, sc_ovf, nxt_carry, nxt_ovf;

  logic [WIDTH-1:0] res_q;
  logic             zero_q, neg_q, carry_q, ovf_q;

  assign op    = bus.ALUControl;
  assign a     = bus.A;
  assign b     = bus.B;
  assign shamt = b[SHW-1:0];

  // A finished result in DONE may be replaced in the same cycle it drains.
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign accept        = bus.in_valid & bus.in_ready;

  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
  assign bus.Neg       = neg_q;
  assign bus.Carry     = carry_q;
  assign bus.Overflow  = ovf_q;

  // Carry-out of the ADD and inverted borrow of the SUB share the extra bit.
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = sub_w[WIDTH-1:0];
        sc_carry = ~sub_w[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      // MUL/DIV opcodes (when built in) are produced by the iterative path;
      // everything else is reserved and yields zero.
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Shared 2*WIDTH-bit accumulator:
  //   multiply : {partial product high, remaining multiplier bits}
  //   divide   : {partial remainder, dividend bits / quotient bits}
  logic [SHW-1:0]     counter;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   opnd;       // multiplicand (A) or divisor (B)
  logic               div_q, hi_q;
  logic               ld_div, ld_hi;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   iter_res;

  assign is_iter = op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  assign ld_div  = op inside {OP_DIVU, OP_REMU};
  assign ld_hi   = op inside {OP_MULHU, OP_REMU};

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder shifted left by one, with the next dividend bit brought in;
    // it can exceed WIDTH bits, hence the extra bit.
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next  = '0;
    if (div_q) begin
      // A divisor of zero never makes the trial negative, which yields an
      // all-ones quotient and a remainder equal to the dividend.
      if (!div_trial[WIDTH])
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  assign iter_res = hi_q ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  assign busy     = (state == CALC);
  assign load_res = (accept & ~is_iter) | ((state == CALC) & (counter == '0));
`else
  assign is_iter  = 1'b0;
  assign busy     = 1'b0;
  assign load_res = accept;
`endif

  always_comb begin
    nxt_res   = sc_res;
    nxt_carry = sc_carry;
    nxt_ovf   = sc_ovf;
`ifdef ALU_MULDIV_EN
    if (state == CALC) begin
      nxt_res   = iter_res;
      nxt_carry = 1'b0;
      nxt_ovf   = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
      counter <= '0;
      acc     <= '0;
      opnd    <= '0;
      div_q   <= 1'b0;
      hi_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (is_iter) begin
              state   <= CALC;
              counter <= SHW'(WIDTH - 1);
              opnd    <= ld_div ? b : a;
              acc     <= {{WIDTH{1'b0}}, (ld_div ? a : b)};
              div_q   <= ld_div;
              hi_q    <= ld_hi;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
          end
        end
`ifdef ALU_MULDIV_EN
        CALC: begin
          acc     <= acc_next;
          counter <= counter - SHW'(1);
          if (counter == '0) state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase

      // Result and flags update only when a new result is produced, so they
      // stay frozen while DONE waits for out_ready.
      if (load_res) begin
        res_q   <= nxt_res;
        zero_q  <= (nxt_res == '0);
        neg_q   <= nxt_res[WIDTH-1];
        carry_q <= nxt_carry;
        ovf_q   <= nxt_ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc. The stimulus side pushes the
// expected result, flags and latency at each accepted handshake; a monitor
// compares the front entry when a new result appears and pops it when the
// consumer takes it.
module tb_alu_mc;
  localparam int WIDTH = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int LAT_MD = MD ? WIDTH + 1 : 1;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4, OP_SLT = 4'h5, OP_SLTU = 4'h6, OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8, OP_SRA = 4'h9, OP_MUL = 4'hA, OP_MULHU = 4'hB;
  localparam logic [3:0] OP_DIVU = 4'hC, OP_REMU = 4'hD, OP_RSV0 = 4'hE, OP_RSV1 = 4'hF;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z, n, c, v;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  alu_mc_if #(.WIDTH(WIDTH)) bus ();

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  int   last_acc = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   fresh = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] res,
                              input logic c, input logic v, input int lat);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.z    = (res == 32'h0);
    e.n    = res[31];
    e.c    = c;
    e.v    = v;
    e.lat  = lat;
    e.acc  = 0;
    return e;
  endfunction

  // Monitor: compare on the first cycle a result is visible, pop on transfer.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      fresh = 1'b1;
    end else if (bus.out_valid === 1'b1) begin
      if (fresh) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_result: out_valid with ALUResult=0x%0h, none expected", bus.ALUResult);
        end else begin
          mon_e = sb[0];
          check({mon_e.name, ".res"}, bus.ALUResult, mon_e.res);
          check({mon_e.name, ".zero"}, bus.Zero, mon_e.z);
          check({mon_e.name, ".neg"}, bus.Neg, mon_e.n);
          check({mon_e.name, ".carry"}, bus.Carry, mon_e.c);
          check({mon_e.name, ".ovf"}, bus.Overflow, mon_e.v);
          check({mon_e.name, ".latency"}, cyc - mon_e.acc, mon_e.lat);
        end
      end
      if (bus.out_ready === 1'b1) begin
        if (sb.size() > 0) void'(sb.pop_front());
        fresh = 1'b1;
      end else begin
        fresh = 1'b0;
      end
    end else begin
      fresh = 1'b1;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    bit ok = 1'b0;
    bus.in_valid   = 1'b1;
    bus.A          = a;
    bus.B          = b;
    bus.ALUControl = op;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok       = 1'b1;
        e.acc    = cyc;
        last_acc = cyc;
        sb.push_back(e);
      end
    end
    check({e.name, ".accepted"}, ok, 1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    // Scramble the operands: the op in flight must not see these.
    bus.in_valid   = 1'b0;
    bus.A          = '1;
    bus.B          = '1;
    bus.ALUControl = OP_ADD;
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1'b1;
    end
    check({tag, ".drain"}, ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_acc;
    int ov_cnt;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.A          = '0;
    bus.B          = '0;
    bus.ALUControl = OP_ADD;

    #1;
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.res", bus.ALUResult, 0);
    check("reset.zero", bus.Zero, 0);
    check("reset.neg", bus.Neg, 0);
    check("reset.carry", bus.Carry, 0);
    check("reset.ovf", bus.Overflow, 0);
    check("reset.busy", busy, 0);
    check("reset.in_ready", bus.in_ready, 1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops with out_ready held high.
    issue(OP_ADD, 32'h7FFFFFFF, 32'h1, mk("add_ovf", 32'h80000000, 0, 1, 1));
    first_acc = last_acc;
    issue(OP_SUB, 32'h5, 32'h5, mk("sub_eq", 32'h0, 1, 0, 1));
    issue(OP_SLT, 32'hFFFFFFFF, 32'h1, mk("slt", 32'h1, 0, 0, 1));
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h1, mk("sltu", 32'h0, 0, 0, 1));
    issue(OP_SRA, 32'h80000000, 32'h24, mk("sra", 32'hF8000000, 0, 0, 1));
    issue(OP_SLL, 32'h1, 32'd31, mk("sll", 32'h80000000, 0, 0, 1));
    issue(OP_RSV1, 32'h1234, 32'h5678, mk("rsv_f", 32'h0, 0, 0, 1));
    issue(OP_XOR, 32'hA5A5A5A5, 32'hFFFF0000, mk("xor", 32'h5A5AA5A5, 0, 0, 1));
    issue(OP_SRL, 32'h80000000, 32'h21, mk("srl", 32'h40000000, 0, 0, 1));
    issue(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, mk("and", 32'hF000F000, 0, 0, 1));
    issue(OP_OR, 32'h0F000000, 32'h00F0000F, mk("or", 32'h0FF0000F, 0, 0, 1));
    issue(OP_ADD, 32'hFFFFFFFF, 32'h1, mk("add_wrap", 32'h0, 1, 0, 1));
    issue(OP_SUB, 32'h3, 32'h5, mk("sub_borrow", 32'hFFFFFFFE, 0, 0, 1));
    issue(OP_SUB, 32'h80000000, 32'h1, mk("sub_ovf", 32'h7FFFFFFF, 1, 1, 1));
    check("burst.throughput", last_acc - first_acc, 13);
    drain("burst");

    // Iterative ops (reserved, latency 1, when the option is not built in).
    busy_cnt = 0;
    issue(OP_MUL, 32'hFFFFFFFF, 32'h2, mk("mul", MD ? 32'hFFFFFFFE : 32'h0, 0, 0, LAT_MD));
    issue(OP_MULHU, 32'hFFFFFFFF, 32'h2, mk("mulhu", MD ? 32'h1 : 32'h0, 0, 0, LAT_MD));
    issue(OP_DIVU, 32'd100, 32'd7, mk("divu", MD ? 32'd14 : 32'h0, 0, 0, LAT_MD));
    issue(OP_REMU, 32'd100, 32'd7, mk("remu", MD ? 32'd2 : 32'h0, 0, 0, LAT_MD));
    issue(OP_DIVU, 32'd7, 32'd0, mk("divu_zero", MD ? 32'hFFFFFFFF : 32'h0, 0, 0, LAT_MD));
    issue(OP_REMU, 32'd7, 32'd0, mk("remu_zero", MD ? 32'd7 : 32'h0, 0, 0, LAT_MD));
    drain("muldiv");
    check("muldiv.busy_cycles", busy_cnt, MD ? 6 * WIDTH : 0);

    issue(OP_RSV0, 32'hDEADBEEF, 32'h1, mk("rsv_e", 32'h0, 0, 0, 1));
    drain("rsv_e");

    // Consumer stalls for three cycles while a new op is offered.
    bus.out_ready = 1'b0;
    issue(OP_ADD, 32'd2, 32'd3, mk("hold_add", 32'd5, 0, 0, 1));
    bus.in_valid   = 1'b1;
    bus.A          = 32'd9;
    bus.B          = 32'd9;
    bus.ALUControl = OP_ADD;
    repeat (3) begin
      @(negedge clk);
      check("hold.in_ready", bus.in_ready, 0);
      check("hold.out_valid", bus.out_valid, 1);
      check("hold.res", bus.ALUResult, 32'd5);
      check("hold.zero", bus.Zero, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("hold");

    // Reset pulse while a multiply is in flight (result held if not built in).
    bus.out_ready = 1'b0;
    issue(OP_MUL, 32'hFFFFFFFF, 32'h2, mk("rst_mul", MD ? 32'hFFFFFFFE : 32'h0, 0, 0, LAT_MD));
    repeat (3) @(posedge clk);
    #2;
    check("rst.busy_before", busy, MD);
    rst_n = 1'b0;
    #1;
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.res", bus.ALUResult, 0);
    check("rst.zero", bus.Zero, 0);
    check("rst.neg", bus.Neg, 0);
    sb.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    ov_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov_cnt++;
    end
    check("rst.no_stale_result", ov_cnt, 0);
    @(posedge clk);
    #1;
    issue(OP_ADD, 32'd10, 32'd20, mk("post_rst_add", 32'd30, 0, 0, 1));
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle datapath ALU. Executes the extended RV32I/M-style integer operation set on WIDTH-bit operands behind a valid/ready handshake on both input and output. Results and flags are registered. Sits between the decode/register-read stage and writeback in the multi-cycle core. Stalls the pipeline through the handshake while an iterative multiply or divide is in progress.

## Interface
- WIDTH, 32, operand/result width; ≥ 8, power of two
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUControl  input  4  opcode
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- ALUResult  output  WIDTH  registered result
- Zero  output  1  ALUResult == 0
- Neg  output  1  ALUResult[WIDTH-1]
- Carry  output  1  ADD carry-out; SUB: 1 when A ≥ B unsigned (no borrow); 0 otherwise
- Overflow  output  1  signed overflow for ADD/SUB; 0 otherwise
- busy  output  1  state == CALC

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR. The low four match the legacy 2-bit encoding zero-extended.
- Further opcodes: 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH), 1011 MULHU (high WIDTH, unsigned), 1100 DIVU, 1101 REMU.
- Opcodes 1110, 1111 are reserved: ALUResult = 0, all flags computed from 0 (Zero=1).
- Shift amount is B[log2(WIDTH)-1:0]; upper bits of B are ignored.
- SLT/SLTU produce 0 or 1, zero-extended.
- MUL/MULHU: iterative shift-add, one bit of B per cycle, 2·WIDTH-bit accumulator.
- DIVU/REMU: restoring division, one quotient bit per cycle.
- Divide by zero: DIVU → all ones; REMU → A. There is no exception.
- FSM states:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) with a single-cycle op → DONE. A handshake with MUL/DIV → CALC, load operands, counter = WIDTH-1.
  - CALC: one iteration per cycle. When counter == 0 → DONE, result registered. in_ready=0.
  - DONE: out_valid=1; outputs held stable until out_ready. On out_ready: if in_valid, accept the new operation, same transitions as from IDLE; else → IDLE.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Flags are registered together with ALUResult and valid in the same cycle as out_valid.

## Timing
- Reset (async, rst_n=0): state=IDLE, out_valid=0, ALUResult=0, Zero=0, Neg=0, Carry=0, Overflow=0, busy=0, counter=0.
- Single-cycle ops: out_valid asserts on the edge after acceptance (latency 1). Back-to-back throughput is 1/cycle when out_ready is held high.
- MUL/MULHU/DIVU/REMU: out_valid asserts WIDTH+1 cycles after acceptance; busy is high for WIDTH cycles.
- in_valid while in CALC is ignored; the source must hold it, since in_ready is 0.
- out_ready low in DONE: ALUResult and flags are frozen, and no new operation is accepted.
- rst_n asserted mid-CALC aborts the operation immediately. No result is produced after release.
- A, B and ALUControl are sampled only on the handshake edge. Later changes do not affect the operation in flight.

## Configuration
- ALU_MULDIV_EN defined: opcodes 1010–1101 execute as above, and the CALC state, counter and accumulator are present.
- ALU_MULDIV_EN undefined: opcodes 1010–1101 behave as reserved (result 0, latency 1). CALC is never entered, busy is tied to 0, and the iterative datapath is not synthesised.

## Test plan
- ADD A=0x7FFFFFFF, B=1 → ALUResult=0x80000000, Neg=1, Overflow=1, Carry=0, Zero=0; out_valid exactly 1 cycle after acceptance.
- SUB A=5, B=5 → 0, Zero=1, Carry=1; SLT A=0xFFFFFFFF, B=1 → 1; SLTU with the same operands → 0.
- SRA A=0x80000000, B=0x24 (shift 4) → 0xF8000000; SLL A=1, B=31 → 0x80000000; opcode 1111 → 0, Zero=1.
- MUL A=0xFFFFFFFF, B=2 → 0xFFFFFFFE; MULHU with the same operands → 1; out_valid 33 cycles after acceptance, busy high for 32 cycles. Without ALU_MULDIV_EN → 0 after 1 cycle.
- DIVU A=100, B=7 → 14; REMU → 2; DIVU A=7, B=0 → 0xFFFFFFFF; REMU A=7, B=0 → 7.
- Hold out_ready=0 for 3 cycles in DONE → outputs stable and in_ready=0. Pulse rst_n low mid-MUL → out_valid=0 and state IDLE immediately, and no stale result appears after release.
